// File: rtl/store_commit_drain_pkg.sv
// Shared constants, types and helpers for the store-queue retire/drain block.
// SIZE_LSQ_LOG must stay >= 3 so the occupancy and stall arithmetic keep their meaning.
package store_commit_drain_pkg;

    localparam int SIZE_LSQ_LOG = 4;
    localparam int SIZE_LSQ     = 1 << SIZE_LSQ_LOG;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int DISP_WIDTH   = 4;

    // Ring index (wraps modulo SIZE_LSQ) and occupancy count (0..SIZE_LSQ).
    typedef logic [SIZE_LSQ_LOG-1:0] stq_idx_t;
    typedef logic [SIZE_LSQ_LOG:0]   stq_cnt_t;

    localparam stq_idx_t IDX_ZERO    = {SIZE_LSQ_LOG{1'b0}};
    localparam stq_idx_t IDX_ONE     = {{(SIZE_LSQ_LOG-1){1'b0}}, 1'b1};
    localparam stq_cnt_t CNT_ZERO    = {(SIZE_LSQ_LOG+1){1'b0}};
    localparam stq_cnt_t CNT_ONE     = {{SIZE_LSQ_LOG{1'b0}}, 1'b1};
    // Dispatch must stall once fewer than DISP_WIDTH entries remain free.
    localparam stq_cnt_t STALL_LIMIT = stq_cnt_t'(SIZE_LSQ - DISP_WIDTH);

    // Bit 0 doubles as the D-cache request valid.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    // One D-cache write request as captured from the STQ RAM.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BE_WIDTH-1:0]   byte_en;
    } stq_req_t;

    // A commit can never retire more stores than are still uncommitted.
    function automatic stq_cnt_t clamp_commit(input stq_cnt_t req, input stq_cnt_t avail);
        return (req > avail) ? avail : req;
    endfunction

endpackage

// File: rtl/store_commit_drain_if.sv
// STQ RAM read port plus D-cache write port of the drain unit.
// master = drain unit (store_commit_drain), slave = STQ RAM / D-cache side.
interface store_commit_drain_if;
    import store_commit_drain_pkg::*;

    logic [SIZE_LSQ_LOG-1:0] rdIndex_o;
    logic [ADDR_WIDTH-1:0]   rdAddr_i;
    logic [DATA_WIDTH-1:0]   rdData_i;
    logic [BE_WIDTH-1:0]     rdByteEn_i;
    logic                    dcWrValid_o;
    logic [ADDR_WIDTH-1:0]   dcWrAddr_o;
    logic [DATA_WIDTH-1:0]   dcWrData_o;
    logic [BE_WIDTH-1:0]     dcWrByteEn_o;
    logic                    dcWrReady_i;

    modport master (
        output rdIndex_o,
        input  rdAddr_i,
        input  rdData_i,
        input  rdByteEn_i,
        output dcWrValid_o,
        output dcWrAddr_o,
        output dcWrData_o,
        output dcWrByteEn_o,
        input  dcWrReady_i
    );

    modport slave (
        input  rdIndex_o,
        output rdAddr_i,
        output rdData_i,
        output rdByteEn_i,
        input  dcWrValid_o,
        input  dcWrAddr_o,
        input  dcWrData_o,
        input  dcWrByteEn_o,
        output dcWrReady_i
    );

endinterface

// File: rtl/store_commit_drain_ptr_ctrl.sv
// STQ pointer bookkeeping: head/tail/occupancy/commit-pending registers,
// flush recovery, dispatch stall and the sticky over-commit error.
module stq_ptr_ctrl
    import store_commit_drain_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_alloc_valid,
    input  stq_idx_t i_cnt_st_new,
    input  stq_idx_t i_commit_st,
    input  logic     i_flush,
    input  logic     i_drain,
    output stq_idx_t o_head,
    output stq_idx_t o_tail,
    output stq_cnt_t o_insts,
    output stq_cnt_t o_commit_pend,
    output stq_cnt_t o_commit_pend_next,
    output logic     o_stall,
    output logic     o_commit_err
);

    stq_idx_t r_head;
    stq_idx_t r_tail;
    stq_cnt_t r_insts;
    stq_cnt_t r_commit_pend;
    logic     r_stall;
    logic     r_commit_err;

    stq_cnt_t w_alloc;
    stq_cnt_t w_drn;
    stq_cnt_t w_avail;
    stq_cnt_t w_commit_req;
    stq_cnt_t w_commit;
    logic     w_over;
    stq_cnt_t w_pend_next;
    stq_idx_t w_head_next;
    stq_idx_t w_tail_next;
    stq_cnt_t w_insts_next;

    // Next-state arithmetic; commits are applied before a flush rebuilds the tail.
    always_comb begin
        w_alloc      = i_alloc_valid ? {1'b0, i_cnt_st_new} : CNT_ZERO;
        w_drn        = i_drain ? CNT_ONE : CNT_ZERO;
        w_avail      = r_insts - r_commit_pend;
        w_commit_req = {1'b0, i_commit_st};
        w_over       = (w_commit_req > w_avail);
        w_commit     = clamp_commit(w_commit_req, w_avail);
        w_pend_next  = r_commit_pend + w_commit - w_drn;
        w_head_next  = r_head + (i_drain ? IDX_ONE : IDX_ZERO);
        if (i_flush) begin
            // Only committed stores survive; they sit contiguously from the new head.
            w_tail_next  = w_head_next + w_pend_next[SIZE_LSQ_LOG-1:0];
            w_insts_next = w_pend_next;
        end else begin
            w_tail_next  = r_tail + w_alloc[SIZE_LSQ_LOG-1:0];
            w_insts_next = r_insts + w_alloc - w_drn;
        end
    end

    // Pointer, count, stall and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head        <= IDX_ZERO;
            r_tail        <= IDX_ZERO;
            r_insts       <= CNT_ZERO;
            r_commit_pend <= CNT_ZERO;
            r_stall       <= 1'b0;
            r_commit_err  <= 1'b0;
        end else begin
            r_head        <= w_head_next;
            r_tail        <= w_tail_next;
            r_insts       <= w_insts_next;
            r_commit_pend <= w_pend_next;
            r_stall       <= (w_insts_next > STALL_LIMIT);
            r_commit_err  <= r_commit_err | w_over;
        end
    end

    assign o_head             = r_head;
    assign o_tail             = r_tail;
    assign o_insts            = r_insts;
    assign o_commit_pend      = r_commit_pend;
    assign o_commit_pend_next = w_pend_next;
    assign o_stall            = r_stall;
    assign o_commit_err       = r_commit_err;

endmodule

// File: rtl/store_commit_drain.sv
// Retire end of the store queue: counts committed stores and drains them in
// order from the STQ head into the D-cache write port, one per cycle.
// The request register holds a captured entry stable until it is accepted.
module store_commit_drain
    import store_commit_drain_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 allocValid_i,
    input  logic [SIZE_LSQ_LOG-1:0] cntStNew_i,
    input  logic [SIZE_LSQ_LOG-1:0] commitSt_i,
    input  logic                 flush_i,
    output logic [SIZE_LSQ_LOG-1:0] stqHead_o,
    output logic [SIZE_LSQ_LOG-1:0] stqTail_o,
    output logic [SIZE_LSQ_LOG:0]   stqInsts_o,
    output logic                 stallDispatch_o,
    output logic                 commitErr_o,
    store_commit_drain_if.master dc_if
);

    drain_state_e r_state;
    drain_state_e w_state_next;
    stq_req_t     r_req;
    logic         w_capture;
    logic         w_handshake;
    stq_idx_t     w_rd_index;
    stq_idx_t     w_head;
    stq_cnt_t     w_commit_pend;
    stq_cnt_t     w_commit_pend_next;

    assign w_handshake = (r_state == ST_SEND) & dc_if.dcWrReady_i;

    stq_ptr_ctrl u_ptr_ctrl (
        .clk                (clk),
        .reset              (reset),
        .i_alloc_valid      (allocValid_i),
        .i_cnt_st_new       (cntStNew_i),
        .i_commit_st        (commitSt_i),
        .i_flush            (flush_i),
        .i_drain            (w_handshake),
        .o_head             (w_head),
        .o_tail             (stqTail_o),
        .o_insts            (stqInsts_o),
        .o_commit_pend      (w_commit_pend),
        .o_commit_pend_next (w_commit_pend_next),
        .o_stall            (stallDispatch_o),
        .o_commit_err       (commitErr_o)
    );

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, RAM read index and capture strobe; in SEND the RAM is read
    // one ahead so the next committed entry is ready at the handshake.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_rd_index   = w_head;
        case (r_state)
            ST_IDLE: begin
                w_rd_index = w_head;
                if (w_commit_pend != CNT_ZERO) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_rd_index = w_head + IDX_ONE;
                if (w_handshake) begin
                    if (w_commit_pend_next != CNT_ZERO) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_SEND;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_SEND;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request register: loads on capture, otherwise holds the pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= '{addr: {ADDR_WIDTH{1'b0}}, data: {DATA_WIDTH{1'b0}}, byte_en: {BE_WIDTH{1'b0}}};
        end else if (w_capture) begin
            r_req <= '{addr: dc_if.rdAddr_i, data: dc_if.rdData_i, byte_en: dc_if.rdByteEn_i};
        end else begin
            r_req <= r_req;
        end
    end

    assign stqHead_o          = w_head;
    assign dc_if.rdIndex_o    = w_rd_index;
    assign dc_if.dcWrValid_o  = (r_state == ST_SEND);
    assign dc_if.dcWrAddr_o   = r_req.addr;
    assign dc_if.dcWrData_o   = r_req.data;
    assign dc_if.dcWrByteEn_o = r_req.byte_en;

endmodule

// File: tb/tb_store_commit_drain.sv
// Directed bench for store_commit_drain. The STQ RAM is modelled as a fixed
// pattern derived from the read index, so every expected request is known.
module tb_store_commit_drain;
    import store_commit_drain_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       allocValid_i;
    logic [3:0] cntStNew_i;
    logic [3:0] commitSt_i;
    logic       flush_i;
    logic [3:0] stqHead_o;
    logic [3:0] stqTail_o;
    logic [4:0] stqInsts_o;
    logic       stallDispatch_o;
    logic       commitErr_o;

    int n_checks = 0;
    int n_fail   = 0;

    store_commit_drain_if u_if ();

    store_commit_drain u_dut (
        .clk             (clk),
        .reset           (reset),
        .allocValid_i    (allocValid_i),
        .cntStNew_i      (cntStNew_i),
        .commitSt_i      (commitSt_i),
        .flush_i         (flush_i),
        .stqHead_o       (stqHead_o),
        .stqTail_o       (stqTail_o),
        .stqInsts_o      (stqInsts_o),
        .stallDispatch_o (stallDispatch_o),
        .commitErr_o     (commitErr_o),
        .dc_if           (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input int i);
        return 32'h1000_0000 + 32'(i * 4);
    endfunction
    function automatic logic [31:0] exp_data(input int i);
        return 32'hA5A5_0000 + 32'(i * 3 + 1);
    endfunction
    function automatic logic [3:0] exp_be(input int i);
        return 4'(i) ^ 4'hF;
    endfunction

    assign u_if.rdAddr_i   = exp_addr(int'(u_if.rdIndex_o));
    assign u_if.rdData_i   = exp_data(int'(u_if.rdIndex_o));
    assign u_if.rdByteEn_i = exp_be(int'(u_if.rdIndex_o));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        allocValid_i = 1'b0;
        cntStNew_i   = 4'd0;
        commitSt_i   = 4'd0;
        flush_i      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        u_if.dcWrReady_i = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic alloc(input int n);
        allocValid_i = 1'b1;
        cntStNew_i   = 4'(n);
        tick();
        allocValid_i = 1'b0;
        cntStNew_i   = 4'd0;
    endtask

    initial begin
        logic done;
        idle_inputs();
        u_if.dcWrReady_i = 1'b0;
        reset = 1'b0;
        #12;
        // Reset state
        chk("rst_head",   32'(stqHead_o), 32'd0);
        chk("rst_tail",   32'(stqTail_o), 32'd0);
        chk("rst_insts",  32'(stqInsts_o), 32'd0);
        chk("rst_stall",  32'(stallDispatch_o), 32'd0);
        chk("rst_valid",  32'(u_if.dcWrValid_o), 32'd0);
        chk("rst_err",    32'(commitErr_o), 32'd0);
        reset = 1'b1;

        // 1: four stores, back-to-back drain
        alloc(4);
        chk("t1_tail", 32'(stqTail_o), 32'd4);
        chk("t1_insts", 32'(stqInsts_o), 32'd4);
        commitSt_i = 4'd4;
        u_if.dcWrReady_i = 1'b1;
        tick();
        commitSt_i = 4'd0;
        chk("t1_no_valid_at_commit", 32'(u_if.dcWrValid_o), 32'd0);
        tick();
        chk("t1_valid_rise", 32'(u_if.dcWrValid_o), 32'd1);
        chk("t1_addr0", u_if.dcWrAddr_o, exp_addr(0));
        chk("t1_data0", u_if.dcWrData_o, exp_data(0));
        chk("t1_be0",   32'(u_if.dcWrByteEn_o), 32'(exp_be(0)));
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_b2b_valid", 32'(u_if.dcWrValid_o), 32'd1);
            chk("t1_b2b_addr", u_if.dcWrAddr_o, exp_addr(k));
            chk("t1_b2b_data", u_if.dcWrData_o, exp_data(k));
        end
        tick();
        chk("t1_valid_drop", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t1_head", 32'(stqHead_o), 32'd4);
        chk("t1_insts_end", 32'(stqInsts_o), 32'd0);

        // 2: back-pressure holds the request stable
        do_reset();
        alloc(2);
        commitSt_i = 4'd2;
        tick();
        commitSt_i = 4'd0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 32'(u_if.dcWrValid_o), 32'd1);
            chk("t2_hold_addr", u_if.dcWrAddr_o, exp_addr(0));
            chk("t2_hold_data", u_if.dcWrData_o, exp_data(0));
            chk("t2_hold_head", 32'(stqHead_o), 32'd0);
            tick();
        end
        chk("t2_still_addr0", u_if.dcWrAddr_o, exp_addr(0));
        u_if.dcWrReady_i = 1'b1;
        tick();
        chk("t2_addr1", u_if.dcWrAddr_o, exp_addr(1));
        chk("t2_head1", 32'(stqHead_o), 32'd1);
        tick();
        chk("t2_valid_drop", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t2_head2", 32'(stqHead_o), 32'd2);
        chk("t2_insts", 32'(stqInsts_o), 32'd0);

        // 3: move head to 14, then stall threshold and wrap-around reads
        do_reset();
        u_if.dcWrReady_i = 1'b1;
        alloc(4);
        commitSt_i = 4'd4; alloc(4);
        commitSt_i = 4'd4; alloc(4);
        commitSt_i = 4'd4; alloc(2);
        commitSt_i = 4'd2; tick();
        commitSt_i = 4'd0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            done = (stqHead_o == 4'd14) && !u_if.dcWrValid_o;
        end
        chk("t3_drain_done", 32'(done), 32'd1);
        chk("t3_insts0", 32'(stqInsts_o), 32'd0);
        chk("t3_tail14", 32'(stqTail_o), 32'd14);
        u_if.dcWrReady_i = 1'b0;
        alloc(4); alloc(4); alloc(4);
        chk("t3_insts12", 32'(stqInsts_o), 32'd12);
        chk("t3_stall_at12", 32'(stallDispatch_o), 32'd0);
        alloc(1);
        chk("t3_insts13", 32'(stqInsts_o), 32'd13);
        chk("t3_stall_at13", 32'(stallDispatch_o), 32'd1);
        chk("t3_tail_wrap", 32'(stqTail_o), 32'd11);
        commitSt_i = 4'd1;
        u_if.dcWrReady_i = 1'b1;
        tick();
        commitSt_i = 4'd0;
        tick();
        chk("t3_addr14", u_if.dcWrAddr_o, exp_addr(14));
        tick();
        chk("t3_stall_release", 32'(stallDispatch_o), 32'd0);
        chk("t3_insts_after1", 32'(stqInsts_o), 32'd12);
        chk("t3_head15", 32'(stqHead_o), 32'd15);
        commitSt_i = 4'd3;
        tick();
        commitSt_i = 4'd0;
        tick();
        chk("t3_addr15", u_if.dcWrAddr_o, exp_addr(15));
        tick();
        chk("t3_addr_wrap0", u_if.dcWrAddr_o, exp_addr(0));
        chk("t3_head_wrap0", 32'(stqHead_o), 32'd0);
        tick();
        chk("t3_addr1", u_if.dcWrAddr_o, exp_addr(1));
        tick();
        chk("t3_valid_drop", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t3_head2", 32'(stqHead_o), 32'd2);
        chk("t3_insts9", 32'(stqInsts_o), 32'd9);

        // 4: flush with a same-cycle commit (and an ignored alloc)
        do_reset();
        alloc(4);
        alloc(2);
        commitSt_i = 4'd2;
        tick();
        commitSt_i   = 4'd1;
        flush_i      = 1'b1;
        allocValid_i = 1'b1;
        cntStNew_i   = 4'd2;
        tick();
        idle_inputs();
        chk("t4_tail", 32'(stqTail_o), 32'd3);
        chk("t4_insts", 32'(stqInsts_o), 32'd3);
        chk("t4_head", 32'(stqHead_o), 32'd0);
        chk("t4_valid", 32'(u_if.dcWrValid_o), 32'd1);
        chk("t4_addr0", u_if.dcWrAddr_o, exp_addr(0));
        u_if.dcWrReady_i = 1'b1;
        tick();
        chk("t4_addr1", u_if.dcWrAddr_o, exp_addr(1));
        tick();
        chk("t4_addr2", u_if.dcWrAddr_o, exp_addr(2));
        tick();
        chk("t4_valid_drop", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t4_head3", 32'(stqHead_o), 32'd3);
        chk("t4_insts0", 32'(stqInsts_o), 32'd0);
        chk("t4_tail3", 32'(stqTail_o), 32'd3);

        // 5: over-commit sets the sticky error and is clamped
        do_reset();
        alloc(2);
        commitSt_i = 4'd2;
        tick();
        chk("t5_err_clear", 32'(commitErr_o), 32'd0);
        commitSt_i = 4'd1;
        tick();
        commitSt_i = 4'd0;
        chk("t5_err_set", 32'(commitErr_o), 32'd1);
        chk("t5_valid", 32'(u_if.dcWrValid_o), 32'd1);
        tick();
        chk("t5_err_sticky", 32'(commitErr_o), 32'd1);
        u_if.dcWrReady_i = 1'b1;
        tick();
        chk("t5_addr1", u_if.dcWrAddr_o, exp_addr(1));
        tick();
        chk("t5_only_two", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t5_insts0", 32'(stqInsts_o), 32'd0);
        chk("t5_err_still", 32'(commitErr_o), 32'd1);

        // 6: asynchronous reset while a request is outstanding
        u_if.dcWrReady_i = 1'b0;
        alloc(2);
        commitSt_i = 4'd2;
        tick();
        commitSt_i = 4'd0;
        tick();
        chk("t6_valid_pre", 32'(u_if.dcWrValid_o), 32'd1);
        chk("t6_addr_pre", u_if.dcWrAddr_o, exp_addr(2));
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t6_addr", u_if.dcWrAddr_o, 32'd0);
        chk("t6_data", u_if.dcWrData_o, 32'd0);
        chk("t6_be", 32'(u_if.dcWrByteEn_o), 32'd0);
        chk("t6_rdidx", 32'(u_if.rdIndex_o), 32'd0);
        chk("t6_head", 32'(stqHead_o), 32'd0);
        chk("t6_tail", 32'(stqTail_o), 32'd0);
        chk("t6_insts", 32'(stqInsts_o), 32'd0);
        chk("t6_err", 32'(commitErr_o), 32'd0);
        chk("t6_stall", 32'(stallDispatch_o), 32'd0);
        reset = 1'b1;
        tick();
        chk("t6_idle_valid", 32'(u_if.dcWrValid_o), 32'd0);
        chk("t6_idle_insts", 32'(stqInsts_o), 32'd0);
        chk("t6_idle_head", 32'(stqHead_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
